seven_seg_interface: RTL and testbench

Drives a 6-digit multiplexed seven-segment display from a 32-bit value written through a simple write-enable/ready handshake. Two display modes, selected per write by `base`:
- Hexadecimal: direct nibble mapping.
- Decimal: serial binary-to-BCD conversion.

The block sits between a host/control FSM and the board's common-anode segment and digit-select pins.

---
 rtl/seven_seg_interface_if.sv | 11 +
 rtl/seven_seg_interface.sv | 173 +++++++++++++++++
 tb/tb_seven_seg_interface.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_interface_if.sv
// Host-side write channel of the seven-segment driver: value, mode and handshake.
interface seven_seg_interface_if;
  logic [31:0] data;
  logic        wen;
  logic        base;
  logic        rdy;
  logic        done;

  modport master (output data, wen, base, input rdy, done);
  modport slave  (input data, wen, base, output rdy, done);
endinterface

// File: rtl/seven_seg_interface.sv
// Six-digit multiplexed common-anode display driver with hex and serial double-dabble decimal modes.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero digit.
module seven_seg_interface #(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_interface_if.slave  bus,
  output logic [7:0]            leds_o,
  output logic [NUM_DIGITS-1:0] sels_o
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  function automatic logic [39:0] dabble_adj(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_lut(input logic [3:0] n);
    case (n)
      4'h0: seg_lut = 8'hC0;  4'h1: seg_lut = 8'hF9;
      4'h2: seg_lut = 8'hA4;  4'h3: seg_lut = 8'hB0;
      4'h4: seg_lut = 8'h99;  4'h5: seg_lut = 8'h92;
      4'h6: seg_lut = 8'h82;  4'h7: seg_lut = 8'hF8;
      4'h8: seg_lut = 8'h80;  4'h9: seg_lut = 8'h90;
      4'hA: seg_lut = 8'h88;  4'hB: seg_lut = 8'h83;
      4'hC: seg_lut = 8'hC6;  4'hD: seg_lut = 8'hA1;
      4'hE: seg_lut = 8'h86;  default: seg_lut = 8'h8E;
    endcase
  endfunction

  state_t                     state_q, state_d;
  logic [31:0]                bin_q, bin_d;
  logic [39:0]                bcd_q, bcd_d;
  logic [4:0]                 step_q, step_d;
  logic                       hex_pend_q, hex_pend_d;
  logic [NUM_DIGITS-1:0][3:0] buf_q, buf_d;
  logic                       ovf_q, ovf_d;
  logic                       done_q, done_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 idx_q, idx_d;
  logic [NUM_DIGITS-1:0]      sels_q, sels_d;
  logic [7:0]                 leds_q, leds_d;
  logic                       rdy;
  logic                       accept;
  logic [39:0]                bcd_adj;

  assign rdy      = (state_q == S_IDLE);
  assign accept   = bus.wen && rdy;
  assign bus.rdy  = rdy;
  assign bus.done = done_q;
  assign leds_o   = leds_q;
  assign sels_o   = sels_q;
  assign bcd_adj  = dabble_adj(bcd_q);

  // Write acceptance, conversion sequencing and display-buffer update
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    hex_pend_d = 1'b0;
    buf_d      = buf_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    // bin_q holds the pending hex value one cycle, so a new write here can safely overwrite it
    if (hex_pend_q) begin
      buf_d  = bin_q[23:0];
      ovf_d  = |bin_q[31:24];
      done_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          bin_d = bus.data;
          if (bus.base) begin
            hex_pend_d = 1'b1;
          end else begin
            bcd_d   = '0;
            step_d  = '0;
            state_d = S_CONV;
          end
        end
      end
      S_CONV: begin
        bcd_d  = {bcd_adj[38:0], bin_q[31]};
        bin_d  = {bin_q[30:0], 1'b0};
        step_d = step_q + 5'd1;
        if (step_q == 5'd31) state_d = S_LOAD;
      end
      S_LOAD: begin
        buf_d   = bcd_q[23:0];
        ovf_d   = |bcd_q[39:24];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Digit scan; segments are derived from the next-state buffer so leds and sels move together
  always_comb begin
    logic [3:0] digit;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
    sels_d = ~(NUM_DIGITS'(1) << idx_d);

    digit = buf_d[0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_d == 3'(i)) digit = buf_d[i];
    end
    leds_d = seg_lut(digit);

`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic hi_zero;
      hi_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (hi_zero && (buf_d[i] == 4'd0)) begin
          if (idx_d == 3'(i)) leds_d = 8'hFF;
        end else begin
          hi_zero = 1'b0;
        end
      end
    end
`endif

    if (ovf_d) leds_d[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hex_pend_q <= 1'b0;
      done_q     <= 1'b0;
      buf_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      sels_q     <= ~NUM_DIGITS'(1);
      leds_q     <= 8'hC0;
    end else begin
      state_q    <= state_d;
      hex_pend_q <= hex_pend_d;
      done_q     <= done_d;
      buf_q      <= buf_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sels_q     <= sels_d;
      leds_q     <= leds_d;
    end
  end

  always_ff @(posedge clk) begin
    bin_q  <= bin_d;
    bcd_q  <= bcd_d;
    step_q <= step_d;
  end
endmodule

// File: tb/tb_seven_seg_interface.sv
// Scoreboard bench for seven_seg_interface with a short scan period.
module tb_seven_seg_interface;
  localparam int SCAN = 4;
  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [5:0][7:0] pat;
    int              lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] leds_o;
  logic [5:0] sels_o;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];

  seven_seg_interface_if bus_if ();

  seven_seg_interface #(.SCAN_DIV(SCAN), .NUM_DIGITS(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if.slave),
    .leds_o (leds_o),
    .sels_o (sels_o)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0][7:0] exp_pattern(input logic [31:0] v, input bit hex);
    logic [5:0][7:0] r;
    logic [3:0]      dg [6];
    bit              ovf;
    bit              blank [6];
    longint unsigned t;
    t = v;
    for (int i = 0; i < 6; i++) begin
      if (hex) dg[i] = v[4*i +: 4];
      else begin
        dg[i] = 4'(t % 10);
        t = t / 10;
      end
      blank[i] = 1'b0;
    end
    ovf = hex ? (|v[31:24]) : (v > 32'd999999);
`ifdef LEADING_ZERO_BLANK_EN
    begin
      bit hz;
      hz = 1'b1;
      for (int i = 5; i > 0; i--) begin
        if (hz && dg[i] == 4'd0) blank[i] = 1'b1;
        else hz = 1'b0;
      end
    end
`endif
    for (int i = 0; i < 6; i++) begin
      r[i] = blank[i] ? 8'hFF : SEG_TAB[dg[i]];
      if (ovf) r[i][7] = 1'b0;
    end
    return r;
  endfunction

  // Drives a one-cycle write at the current negedge; returns at the following negedge.
  task automatic do_write(input logic [31:0] v, input bit hex, output bit accepted);
    exp_t e;
    bus_if.data = v;
    bus_if.base = hex;
    bus_if.wen  = 1'b1;
    accepted    = bus_if.rdy;
    if (accepted) begin
      e.pat = exp_pattern(v, hex);
      e.lat = hex ? 2 : 34;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus_if.wen = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int rdy_low);
    lat = -1;
    rdy_low = 0;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) @(negedge clk);
      if (bus_if.done) begin
        lat = k;
        return;
      end
      if (!bus_if.rdy) rdy_low++;
    end
  endtask

  task automatic capture_display(output logic [5:0][7:0] got, output bit ok);
    ok = 1'b1;
    got = '0;
    for (int d = 0; d < 6; d++) begin
      logic [5:0] want;
      bit found;
      want = ~(6'b1 << d);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        if (sels_o == want) found = 1'b1;
        else @(negedge clk);
      end
      if (!found) ok = 1'b0;
      got[d] = leds_o;
    end
  endtask

  task automatic test_reset;
    logic [5:0][7:0] zp;
    zp = exp_pattern(32'd0, 1'b1);
    bus_if.wen = 1'b0; bus_if.data = '0; bus_if.base = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 26; m++) begin
      int idx;
      logic [5:0] ws;
      if (m > 0) @(negedge clk);
      idx = (m / SCAN) % 6;
      ws = ~(6'b1 << idx);
      checks++;
      if ({sels_o, leds_o, bus_if.rdy, bus_if.done} !== {ws, zp[idx], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_scan m=%0d: sels=%b leds=%h rdy=%b done=%b, required sels=%b leds=%h rdy=1 done=0",
                 m, sels_o, leds_o, bus_if.rdy, bus_if.done, ws, zp[idx]);
      end
    end
  endtask

  task automatic test_hex(input logic [31:0] v, input string nm);
    bit acc, ok;
    int lat, rl;
    exp_t e;
    logic [5:0][7:0] got;
    @(negedge clk);
    do_write(v, 1'b1, acc);
    wait_done(lat, rl);
    checks++;
    if (!acc || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_accept: accepted=%0d, required 1", nm, acc);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat || rl !== 0 || bus_if.rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_timing: latency=%0d rdy_low=%0d rdy=%b, required latency=%0d rdy_low=0 rdy=1",
               nm, lat, rl, bus_if.rdy, e.lat);
    end
    @(negedge clk);
    checks++;
    if (bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: done=%b, required 0", nm, bus_if.done);
    end
    capture_display(got, ok);
    checks++;
    if (!ok || got !== e.pat) begin
      errors++;
      $display("FAIL %s_display: ok=%0d leds=%h, required %h", nm, ok, got, e.pat);
    end
  endtask

  task automatic test_decimal(input logic [31:0] v, input string nm);
    bit acc, ok;
    int lat, rl;
    exp_t e;
    logic [5:0][7:0] got;
    @(negedge clk);
    do_write(v, 1'b0, acc);
    wait_done(lat, rl);
    checks++;
    if (!acc || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_accept: accepted=%0d, required 1", nm, acc);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat || rl !== 33 || bus_if.rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_timing: latency=%0d rdy_low=%0d rdy=%b, required latency=%0d rdy_low=33 rdy=1",
               nm, lat, rl, bus_if.rdy, e.lat);
    end
    @(negedge clk);
    checks++;
    if (bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_width: done=%b, required 0", nm, bus_if.done);
    end
    capture_display(got, ok);
    checks++;
    if (!ok || got !== e.pat) begin
      errors++;
      $display("FAIL %s_display: ok=%0d leds=%h, required %h", nm, ok, got, e.pat);
    end
  endtask

  task automatic test_ignore_busy;
    bit acc, ok;
    int ndone, dk;
    exp_t e;
    logic [5:0][7:0] got;
    @(negedge clk);
    do_write(32'd654321, 1'b0, acc);
    ndone = 0;
    dk = -1;
    for (int k = 1; k <= 80; k++) begin
      if (bus_if.done) begin
        ndone++;
        dk = k;
      end
      if (k == 5) begin
        bus_if.data = 32'd999; bus_if.base = 1'b1; bus_if.wen = 1'b1;
        checks++;
        if (bus_if.rdy !== 1'b0) begin
          errors++;
          $display("FAIL busy_rdy: rdy=%b, required 0", bus_if.rdy);
        end
      end else begin
        bus_if.wen = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (!acc || ndone !== 1 || dk !== 34 || exp_q.size() !== 1) begin
      errors++;
      $display("FAIL busy_done: accepted=%0d pulses=%0d at=%0d queued=%0d, required 1 pulse at 34 queued=1",
               acc, ndone, dk, exp_q.size());
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    capture_display(got, ok);
    checks++;
    if (!ok || got !== e.pat) begin
      errors++;
      $display("FAIL busy_display: ok=%0d leds=%h, required %h", ok, got, e.pat);
    end
  endtask

  task automatic test_back_to_back;
    bit acc1, acc2;
    int lat, rl;
    exp_t e;
    logic [5:0][7:0] got;
    bit ok;
    @(negedge clk);
    do_write(32'd42, 1'b0, acc1);
    wait_done(lat, rl);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++;
    if (!acc1 || lat !== 34) begin
      errors++;
      $display("FAIL b2b_first: accepted=%0d latency=%0d, required 1 and 34", acc1, lat);
    end
    do_write(32'h00ABCDEF, 1'b1, acc2);
    checks++;
    if (!acc2) begin
      errors++;
      $display("FAIL b2b_accept: accepted=%0d, required 1", acc2);
      return;
    end
    wait_done(lat, rl);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL b2b_latency: latency=%0d, required 2", lat);
    end
    capture_display(got, ok);
    checks++;
    if (!ok || got !== e.pat) begin
      errors++;
      $display("FAIL b2b_display: ok=%0d leds=%h, required %h", ok, got, e.pat);
    end
  endtask

  task automatic test_reset_abort;
    bit acc, ok;
    int ndone;
    logic [5:0][7:0] got, zp;
    zp = exp_pattern(32'd0, 1'b1);
    @(negedge clk);
    do_write(32'd777777, 1'b0, acc);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (!acc || bus_if.rdy !== 1'b1 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_rdy: accepted=%0d rdy=%b done=%b, required 1 1 0", acc, bus_if.rdy, bus_if.done);
    end
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus_if.done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL abort_done: pulses=%0d, required 0", ndone);
    end
    capture_display(got, ok);
    checks++;
    if (!ok || got !== zp) begin
      errors++;
      $display("FAIL abort_display: ok=%0d leds=%h, required %h", ok, got, zp);
    end
  endtask

  initial begin
    test_reset();
    test_hex(32'h00000101, "hex_101");
    test_decimal(32'd123456, "dec_123456");
    test_decimal(32'd1234567, "dec_ovf");
    test_hex(32'h01000000, "hex_ovf");
    test_decimal(32'd0, "dec_zero");
    test_decimal(32'hFFFFFFFF, "dec_max");
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: queued=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
